// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream requester bundle plus transmitter write/credit port for uart_tx_arbiter.
//   req_valid/req_data/req_last : per-requester byte streams (requester i on req_data[8i+7:8i])
//   req_ready                   : per-requester byte accept (only the granted requester)
//   tx_start/tx_in              : one-cycle write strobe and byte into the transmitter
//   tx_done                     : transmitter pulse, one per byte fully sent (credit return)
interface uart_tx_arbiter_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_done;
    logic           tx_start;
    logic [7:0]     tx_in;

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_in
    );

    // Requesters + transmitter side
    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_in
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter sharing one UART transmitter between N requesters.
// Each granted frame is SOF, source ID, payload bytes, XOR checksum. Bytes are
// only issued while fewer than DEPTH are outstanding; tx_done returns credit.
//   clk          : baud clock shared with the transmitter
//   enable       : asynchronous active-low reset
//   bus          : requester streams and transmitter write/done port
//   grant_id     : current or most recent granted requester
//   frame_active : high from grant until the checksum byte is issued
//   truncated    : one-cycle pulse when a frame is cut at MAX_LEN
//   frames_sent  : completed-frame counter (wraps)
//   outstanding  : bytes issued but not yet returned by tx_done
module uart_tx_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned DEPTH    = 16,
    parameter logic [7:0]  SOF_BYTE = 8'h7E
) (
    input  logic              clk,
    input  logic              enable,
    uart_tx_arbiter_if.slave  bus,
    output logic [2:0]        grant_id,
    output logic              frame_active,
    output logic              truncated,
    output logic [15:0]       frames_sent,
    output logic [4:0]        outstanding
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_HDR,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  tx_in_q, tx_in_d;
    logic        tx_start_q, tx_start_d;
    logic        fa_q, fa_d;
    logic        trunc_q, trunc_d;
    logic [15:0] frames_q, frames_d;
    logic [4:0]  outst_q, outst_d;

    logic          avail_c;
    logic [N-1:0]  ready_c;
    logic [IW-1:0] gidx;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;
    logic          dec;
    logic [7:0]    req_byte [N];

    assign avail_c = (outst_q < 5'(DEPTH));
    assign gidx    = IW'(grant_q);

    // Split the flat data bus into per-requester bytes
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            req_byte[i] = bus.req_data[8*i +: 8];
        end
    end

    // Round-robin search upward from ptr+1, wrapping modulo N
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr_q) + k) % N);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Frame sequencing, byte issue and credit accounting
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        csum_d     = csum_q;
        len_d      = len_q;
        fa_d       = fa_q;
        trunc_d    = 1'b0;
        frames_d   = frames_q;
        tx_start_d = 1'b0;
        tx_in_d    = tx_in_q;
        ready_c    = '0;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = 3'(win);
                    fa_d    = 1'b1;
                    state_d = S_SOF;
                end
            end
            S_SOF: begin
                if (avail_c) begin
                    tx_start_d = 1'b1;
                    tx_in_d    = SOF_BYTE;
                    csum_d     = 8'h00;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (avail_c) begin
                    tx_start_d = 1'b1;
                    tx_in_d    = {5'b0, grant_q};
                    csum_d     = {5'b0, grant_q};
                    len_d      = 8'h00;
                    state_d    = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                ready_c[gidx] = avail_c;
                if (avail_c && bus.req_valid[gidx]) begin
                    tx_start_d = 1'b1;
                    tx_in_d    = req_byte[gidx];
                    csum_d     = csum_q ^ req_byte[gidx];
                    len_d      = len_q + 8'd1;
                    if (bus.req_last[gidx]) begin
                        state_d = S_CSUM;
                    end else if ((9'(len_q) + 9'd1) == 9'(MAX_LEN)) begin
                        // Cut here; the requester's remaining bytes form a later frame
                        state_d = S_CSUM;
                        trunc_d = 1'b1;
                    end
                end
            end
            S_CSUM: begin
                if (avail_c) begin
                    tx_start_d = 1'b1;
                    tx_in_d    = csum_q;
                    fa_d       = 1'b0;
                    frames_d   = frames_q + 16'd1;
                    ptr_d      = grant_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A done pulse with nothing outstanding is ignored
        dec = bus.tx_done && (outst_q != 5'd0);
        case ({tx_start_d, dec})
            2'b10:   outst_d = outst_q + 5'd1;
            2'b01:   outst_d = outst_q - 5'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'(N - 1);
            grant_q    <= 3'd0;
            csum_q     <= 8'h00;
            len_q      <= 8'h00;
            fa_q       <= 1'b0;
            trunc_q    <= 1'b0;
            frames_q   <= 16'h0000;
            tx_start_q <= 1'b0;
            tx_in_q    <= 8'h00;
            outst_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            csum_q     <= csum_d;
            len_q      <= len_d;
            fa_q       <= fa_d;
            trunc_q    <= trunc_d;
            frames_q   <= frames_d;
            tx_start_q <= tx_start_d;
            tx_in_q    <= tx_in_d;
            outst_q    <= outst_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_in     = tx_in_q;
    assign grant_id      = grant_q;
    assign frame_active  = fa_q;
    assign truncated     = trunc_q;
    assign frames_sent   = frames_q;
    assign outstanding   = outst_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N=4, MAX_LEN=32, DEPTH=16).
module tb_uart_tx_arbiter;
    logic        clk;
    logic        enable;
    logic [2:0]  grant_id;
    logic        frame_active;
    logic        truncated;
    logic [15:0] frames_sent;
    logic [4:0]  outstanding;

    int vectors;
    int miscompares;

    uart_tx_arbiter_if #(.N(4)) bus ();

    uart_tx_arbiter #(
        .N        (4),
        .MAX_LEN  (32),
        .DEPTH    (16),
        .SOF_BYTE (8'h7E)
    ) dut (
        .clk          (clk),
        .enable       (enable),
        .bus          (bus),
        .grant_id     (grant_id),
        .frame_active (frame_active),
        .truncated    (truncated),
        .frames_sent  (frames_sent),
        .outstanding  (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester byte buffers: {last, byte}
    logic [8:0]  rbuf [4][64];
    int          rh [4];
    int          rt [4];
    logic [7:0]  txq [$];
    int          txc [$];
    int          cyc;
    int          out_m;
    int          trunc_cnt;
    logic        auto_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic last);
        rbuf[r][rt[r]] = {last, b};
        rt[r]++;
    endtask

    // One clock: drive requesters from buffers, pop accepted bytes, capture issued bytes
    task automatic tick();
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic [3:0]  fire;
        logic        done_b;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < 4; i++) begin
            if (rh[i] < rt[i]) begin
                v[i]        = 1'b1;
                d[8*i +: 8] = rbuf[i][rh[i]][7:0];
                l[i]        = rbuf[i][rh[i]][8];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        #1;
        fire   = bus.req_valid & bus.req_ready;
        done_b = bus.tx_done;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (fire[i]) rh[i]++;
        end
        @(negedge clk);
        cyc++;
        if (done_b && out_m != 0) out_m--;
        if (bus.tx_start) begin
            txq.push_back(bus.tx_in);
            txc.push_back(cyc);
            out_m++;
        end
        if (truncated) trunc_cnt++;
        if (auto_done) bus.tx_done = (out_m != 0);
    endtask

    task automatic clear_bench();
        for (int i = 0; i < 4; i++) begin
            rh[i] = 0;
            rt[i] = 0;
        end
        txq.delete();
        txc.delete();
        out_m     = 0;
        trunc_cnt = 0;
        bus.tx_done   = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        clear_bench();
        repeat (2) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic run_bytes(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) tick();
        chk(tag, 32'(txq.size()), 32'(n));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && out_m != 0; i++) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        auto_done   = 1'b0;
        enable      = 1'b0;
        clear_bench();

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_tx_start",     32'(bus.tx_start),  32'h0);
        chk("rst_tx_in",        32'(bus.tx_in),     32'h0);
        chk("rst_grant_id",     32'(grant_id),      32'h0);
        chk("rst_frame_active", 32'(frame_active),  32'h0);
        chk("rst_truncated",    32'(truncated),     32'h0);
        chk("rst_frames_sent",  32'(frames_sent),   32'h0);
        chk("rst_outstanding",  32'(outstanding),   32'h0);
        chk("rst_req_ready",    32'(bus.req_ready), 32'h0);

        // Single requester, 3-byte message
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        auto_done = 1'b1;
        enable    = 1'b1;
        run_bytes("t1_len", 6, 60);
        drain(40);
        chk("t1_b0_sof",     32'(txq[0]), 32'h7E);
        chk("t1_b1_id",      32'(txq[1]), 32'h00);
        chk("t1_b2",         32'(txq[2]), 32'h11);
        chk("t1_b3",         32'(txq[3]), 32'h22);
        chk("t1_b4",         32'(txq[4]), 32'h33);
        chk("t1_b5_csum",    32'(txq[5]), 32'h00);
        chk("t1_frames",     32'(frames_sent),  32'd1);
        chk("t1_outst",      32'(outstanding),  32'd0);
        chk("t1_fa_low",     32'(frame_active), 32'd0);

        // All four requesters valid with 1-byte messages: round-robin from requester 0
        do_reset();
        push(0, 8'hA0, 1'b1); push(0, 8'hB0, 1'b1);
        push(1, 8'hA1, 1'b1); push(1, 8'hB1, 1'b1);
        push(2, 8'hA2, 1'b1); push(2, 8'hB2, 1'b1);
        push(3, 8'hA3, 1'b1); push(3, 8'hB3, 1'b1);
        run_bytes("t2_len", 20, 120);
        chk("t2_id0",   32'(txq[1]),  32'h00);
        chk("t2_id1",   32'(txq[5]),  32'h01);
        chk("t2_id2",   32'(txq[9]),  32'h02);
        chk("t2_id3",   32'(txq[13]), 32'h03);
        chk("t2_id4",   32'(txq[17]), 32'h00);
        chk("t2_sof1",  32'(txq[4]),  32'h7E);
        chk("t2_csum0", 32'(txq[3]),  32'hA0);
        chk("t2_csum1", 32'(txq[7]),  32'hA0);
        chk("t2_csum2", 32'(txq[11]), 32'hA0);
        chk("t2_csum3", 32'(txq[15]), 32'hA0);
        chk("t2_csum4", 32'(txq[19]), 32'hB0);
        chk("t2_gap",   32'(txc[4] - txc[3]), 32'd2);

        // Credit limit with tx_done held low, 40-byte message from requester 1
        do_reset();
        auto_done = 1'b0;
        for (int k = 1; k <= 40; k++) push(1, 8'(k), (k == 40));
        repeat (30) tick();
        chk("t3_cap_len",   32'(txq.size()),    32'd16);
        chk("t3_cap_outst", 32'(outstanding),   32'd16);
        chk("t3_cap_start", 32'(bus.tx_start),  32'd0);
        chk("t3_cap_ready", 32'(bus.req_ready), 32'd0);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        repeat (5) tick();
        chk("t3_one_len",   32'(txq.size()),  32'd17);
        chk("t3_one_outst", 32'(outstanding), 32'd16);
        // Done held high: first edge frees a slot, then issue and done coincide
        bus.tx_done = 1'b1;
        repeat (4) tick();
        chk("t3_sim_len",   32'(txq.size()),   32'd20);
        chk("t3_sim_outst", 32'(outstanding),  32'd15);
        chk("t3_sim_start", 32'(bus.tx_start), 32'd1);
        bus.tx_done = 1'b0;
        repeat (3) tick();
        chk("t3_refill_len",   32'(txq.size()),  32'd21);
        chk("t3_refill_outst", 32'(outstanding), 32'd16);

        // Let the 40-byte message finish: 32-byte truncated frame then 8-byte frame
        auto_done   = 1'b1;
        bus.tx_done = 1'b1;
        run_bytes("t4_len", 46, 400);
        drain(40);
        chk("t4_trunc_cnt", 32'(trunc_cnt),  32'd1);
        chk("t4_f1_last",   32'(txq[33]),    32'h20);
        chk("t4_f1_csum",   32'(txq[34]),    32'h21);
        chk("t4_f2_sof",    32'(txq[35]),    32'h7E);
        chk("t4_f2_id",     32'(txq[36]),    32'h01);
        chk("t4_f2_last",   32'(txq[44]),    32'h28);
        chk("t4_f2_csum",   32'(txq[45]),    32'h09);
        chk("t4_frames",    32'(frames_sent), 32'd2);
        chk("t4_outst",     32'(outstanding), 32'd0);

        // Reset mid-payload from requester 2
        txq.delete();
        txc.delete();
        for (int k = 0; k < 10; k++) push(2, 8'(8'h50 + k), (k == 9));
        run_bytes("t5_pre_len", 5, 60);
        chk("t5_pre_grant", 32'(grant_id),     32'd2);
        chk("t5_pre_fa",    32'(frame_active), 32'd1);
        chk("t5_pre_b4",    32'(txq[4]),       32'h52);
        enable = 1'b0;
        #1;
        chk("t5_rst_tx_start", 32'(bus.tx_start),  32'h0);
        chk("t5_rst_tx_in",    32'(bus.tx_in),     32'h0);
        chk("t5_rst_grant",    32'(grant_id),      32'h0);
        chk("t5_rst_fa",       32'(frame_active),  32'h0);
        chk("t5_rst_frames",   32'(frames_sent),   32'h0);
        chk("t5_rst_outst",    32'(outstanding),   32'h0);
        chk("t5_rst_ready",    32'(bus.req_ready), 32'h0);
        clear_bench();
        repeat (2) @(negedge clk);
        push(1, 8'hC1, 1'b1);
        push(3, 8'hC3, 1'b1);
        enable = 1'b1;
        run_bytes("t5_post_len", 4, 60);
        chk("t5_post_sof",    32'(txq[0]),      32'h7E);
        chk("t5_post_id",     32'(txq[1]),      32'h01);
        chk("t5_post_b",      32'(txq[2]),      32'hC1);
        chk("t5_post_csum",   32'(txq[3]),      32'hC0);
        chk("t5_post_frames", 32'(frames_sent), 32'd1);
        run_bytes("t5_next_len", 8, 60);
        chk("t5_next_id",     32'(txq[5]),      32'h03);
        chk("t5_next_csum",   32'(txq[7]),      32'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
